// File: rtl/command_decode_if.sv
// Bus between the drum timing/control logic and the command decoder.
// The timing side drives the serial inputs; the decoder returns the held command and its decodes.
interface command_decode_if;
  localparam int unsigned WN_W  = 7;
  localparam int unsigned FLD_W = 5;

  logic             T1;
  logic             RC;
  logic             CM;
  logic [WN_W-1:0]  WORD_NUM;

  logic             CMD_VALID;
  logic             SD;
  logic             BP;
  logic             IMM;
  logic [FLD_W-1:0] D_F;
  logic [FLD_W-1:0] S_F;
  logic [1:0]       C_F;
  logic [WN_W-1:0]  N_F;
  logic [WN_W-1:0]  T_F;
  logic             D4, D5, D6, D7, DX;
  logic             S4, S5, S6, S7, SU, SV, SW, SX;
  logic             DS;
  logic             T_MATCH, N_MATCH;
  logic             SYNC_ERR;

  modport master (
    output T1, RC, CM, WORD_NUM,
    input  CMD_VALID, SD, BP, IMM, D_F, S_F, C_F, N_F, T_F,
    input  D4, D5, D6, D7, DX, S4, S5, S6, S7, SU, SV, SW, SX, DS,
    input  T_MATCH, N_MATCH, SYNC_ERR
  );

  modport slave (
    input  T1, RC, CM, WORD_NUM,
    output CMD_VALID, SD, BP, IMM, D_F, S_F, C_F, N_F, T_F,
    output D4, D5, D6, D7, DX, S4, S5, S6, S7, SU, SV, SW, SX, DS,
    output T_MATCH, N_MATCH, SYNC_ERR
  );
endinterface

// File: rtl/command_decode.sv
// Serial drum-word command loader: tracks bit time from T1, shifts a 29-bit command in
// LSB first while RC holds, and presents the committed command with its field decodes.
module command_decode (
  input  logic            CLOCK,
  input  logic            rst,
  command_decode_if.slave bus
);
  localparam int unsigned WORD_BITS = 29;
  localparam int unsigned CNT_W     = 5;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS);
  localparam logic [6:0]       WORD_LIMIT = 7'd108;

  typedef enum logic [1:0] {IDLE, LOAD, ABORT} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     bt_c;
  logic                 sync_bad_c;
  logic [WORD_BITS-2:0] shreg_q;
  logic [WORD_BITS-1:0] cmd_q;
  logic                 cmd_held_q;
  logic                 commit_pend_q;
  logic [4:0]           d_c;
  logic [4:0]           s_c;

  assign d_c = cmd_q[5:1];
  assign s_c = cmd_q[10:6];

  // Bit time of the current cycle; cnt_q holds the bit time of the previous cycle (0 = unsynced).
  always_comb begin
    bt_c       = '0;
    sync_bad_c = 1'b0;
    if (bus.T1) begin
      bt_c       = CNT_W'(1);
      sync_bad_c = (cnt_q != '0) && (cnt_q != LAST_BIT);
    end else if (cnt_q == LAST_BIT) begin
      bt_c = CNT_W'(1);
    end else if (cnt_q != '0) begin
      bt_c = cnt_q + CNT_W'(1);
    end
  end

  // Bit counter, load FSM and shift register; bit 29 goes straight into the command register.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shreg_q       <= '0;
      cmd_q         <= '0;
      cmd_held_q    <= 1'b0;
      commit_pend_q <= 1'b0;
      bus.SYNC_ERR  <= 1'b0;
    end else begin
      cnt_q         <= bt_c;
      commit_pend_q <= 1'b0;
      if (sync_bad_c) begin
        bus.SYNC_ERR <= 1'b1;
      end
      case (state_q)
        IDLE, ABORT: begin
          if (bus.T1 && !sync_bad_c && bus.RC) begin
            state_q    <= LOAD;
            shreg_q[0] <= bus.CM;
          end else if (state_q == ABORT && bt_c == LAST_BIT) begin
            state_q <= IDLE;
          end
        end
        LOAD: begin
          if (sync_bad_c || !bus.RC) begin
            state_q <= ABORT;
          end else if (bt_c == LAST_BIT) begin
            cmd_q         <= {bus.CM, shreg_q};
            cmd_held_q    <= 1'b1;
            commit_pend_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            shreg_q[bt_c - CNT_W'(1)] <= bus.CM;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Field and decode outputs follow the command register one edge after a commit.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      bus.CMD_VALID <= 1'b0;
      bus.SD        <= 1'b0;
      bus.BP        <= 1'b0;
      bus.IMM       <= 1'b0;
      bus.D_F       <= '0;
      bus.S_F       <= '0;
      bus.C_F       <= '0;
      bus.N_F       <= '0;
      bus.T_F       <= '0;
      bus.D4        <= 1'b0;
      bus.D5        <= 1'b0;
      bus.D6        <= 1'b0;
      bus.D7        <= 1'b0;
      bus.DX        <= 1'b0;
      bus.DS        <= 1'b0;
      bus.S4        <= 1'b0;
      bus.S5        <= 1'b0;
      bus.S6        <= 1'b0;
      bus.S7        <= 1'b0;
      bus.SU        <= 1'b0;
      bus.SV        <= 1'b0;
      bus.SW        <= 1'b0;
      bus.SX        <= 1'b0;
    end else if (commit_pend_q) begin
      bus.CMD_VALID <= 1'b1;
      bus.SD        <= cmd_q[0];
      bus.D_F       <= d_c;
      bus.S_F       <= s_c;
      bus.C_F       <= cmd_q[12:11];
      bus.N_F       <= cmd_q[19:13];
      bus.BP        <= cmd_q[20];
      bus.T_F       <= cmd_q[27:21];
      bus.IMM       <= cmd_q[28];
      bus.D4        <= (d_c[4:2] == 3'b100);
      bus.D5        <= (d_c[4:2] == 3'b101);
      bus.D6        <= (d_c[4:2] == 3'b110);
      bus.D7        <= (d_c[4:2] == 3'b111);
      bus.DX        <= (d_c[1:0] == 2'b11);
      bus.DS        <= (&d_c);
      bus.S4        <= (s_c[4:2] == 3'b100);
      bus.S5        <= (s_c[4:2] == 3'b101);
      bus.S6        <= (s_c[4:2] == 3'b110);
      bus.S7        <= (s_c[4:2] == 3'b111);
      bus.SU        <= (s_c[1:0] == 2'b00);
      bus.SV        <= (s_c[1:0] == 2'b01);
      bus.SW        <= (s_c[1:0] == 2'b10);
      bus.SX        <= (s_c[1:0] == 2'b11);
    end
  end

  // Word-number compares latched at T1 against the command register, so they agree with
  // the fields that appear on the same edge; drum indices 108..127 do not exist.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      bus.T_MATCH <= 1'b0;
      bus.N_MATCH <= 1'b0;
    end else if (bus.T1) begin
      bus.T_MATCH <= cmd_held_q && (bus.WORD_NUM < WORD_LIMIT) && (bus.WORD_NUM == cmd_q[27:21]);
      bus.N_MATCH <= cmd_held_q && (bus.WORD_NUM < WORD_LIMIT) && (bus.WORD_NUM == cmd_q[19:13]);
    end
  end
endmodule

// File: tb/tb_command_decode.sv
// Directed bench for command_decode: a table of back-to-back words plus hand sequences
// for word-number matching, sync errors and reset in the middle of a load.
module tb_command_decode;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  command_decode_if bus ();

  command_decode dut (
    .CLOCK (clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [28:0] cmd;
    int          drop;
    logic [28:0] e_fld;
    logic [13:0] e_dec;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];
  logic [28:0] idle_w = '0;

  function automatic logic [28:0] mk_cmd(input logic sd, input logic [4:0] d, input logic [4:0] s,
                                         input logic [1:0] c, input logic [6:0] n, input logic bp,
                                         input logic [6:0] t, input logic imm);
    logic [28:0] w;
    w        = '0;
    w[0]     = sd;
    w[5:1]   = d;
    w[10:6]  = s;
    w[12:11] = c;
    w[19:13] = n;
    w[20]    = bp;
    w[27:21] = t;
    w[28]    = imm;
    return w;
  endfunction

  task automatic set_vec(input int i, input logic [28:0] cmd, input int drop,
                         input logic [28:0] efld, input logic [13:0] edec);
    vecs[i].cmd   = cmd;
    vecs[i].drop  = drop;
    vecs[i].e_fld = efld;
    vecs[i].e_dec = edec;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive bits first..last of a word (bit n on CM, T1 on bit 1, RC low from bit 'drop' when nonzero).
  task automatic run_bits(input logic [28:0] cmd, input int drop, input logic [6:0] wn,
                          input int first, input int last);
    for (int n = first; n <= last; n++) begin
      bus.T1       = (n == 1);
      bus.CM       = cmd[n-1];
      bus.RC       = !(drop != 0 && n >= drop);
      bus.WORD_NUM = wn;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  function automatic logic [28:0] act_fld();
    return {bus.SD, bus.BP, bus.IMM, bus.C_F, bus.D_F, bus.S_F, bus.N_F, bus.T_F};
  endfunction

  function automatic logic [13:0] act_dec();
    return {bus.D4, bus.D5, bus.D6, bus.D7, bus.DX, bus.DS,
            bus.S4, bus.S5, bus.S6, bus.S7, bus.SU, bus.SV, bus.SW, bus.SX};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.CMD_VALID), 32'd0);
    chk({tag, "_fld"},   32'(act_fld()), 32'd0);
    chk({tag, "_dec"},   32'(act_dec()), 32'd0);
    chk({tag, "_match"}, 32'({bus.T_MATCH, bus.N_MATCH}), 32'd0);
    chk({tag, "_syncerr"}, 32'(bus.SYNC_ERR), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [28:0] nxt;
    int          nxt_drop;
    logic [6:0]  wn_list [3];

    //          D4..DS = {D4,D5,D6,D7,DX,DS}, then {S4,S5,S6,S7}, then {SU,SV,SW,SX}
    set_vec(0, mk_cmd(1'b0, 5'd31, 5'd16, 2'd0, 7'd5,   1'b0, 7'd7,   1'b0), 0,
            {1'b0, 1'b0, 1'b0, 2'd0, 5'd31, 5'd16, 7'd5, 7'd7},     14'b000111_1000_1000);
    set_vec(1, mk_cmd(1'b0, 5'd31, 5'd21, 2'd0, 7'd5,   1'b0, 7'd7,   1'b0), 15,
            {1'b0, 1'b0, 1'b0, 2'd0, 5'd31, 5'd16, 7'd5, 7'd7},     14'b000111_1000_1000);
    set_vec(2, idle_w, 1,
            {1'b0, 1'b0, 1'b0, 2'd0, 5'd31, 5'd16, 7'd5, 7'd7},     14'b000111_1000_1000);
    set_vec(3, mk_cmd(1'b1, 5'd7,  5'd3,  2'd2, 7'd100, 1'b1, 7'd42,  1'b1), 0,
            {1'b1, 1'b1, 1'b1, 2'd2, 5'd7, 5'd3, 7'd100, 7'd42},    14'b000010_0000_0001);
    set_vec(4, mk_cmd(1'b0, 5'd27, 5'd25, 2'd1, 7'd0,   1'b0, 7'd127, 1'b0), 0,
            {1'b0, 1'b0, 1'b0, 2'd1, 5'd27, 5'd25, 7'd0, 7'd127},   14'b001010_0010_0100);
    set_vec(5, mk_cmd(1'b0, 5'd20, 5'd30, 2'd3, 7'd41,  1'b0, 7'd42,  1'b0), 0,
            {1'b0, 1'b0, 1'b0, 2'd3, 5'd20, 5'd30, 7'd41, 7'd42},   14'b010000_0001_0010);
    set_vec(6, mk_cmd(1'b0, 5'd19, 5'd18, 2'd0, 7'd43,  1'b1, 7'd42,  1'b0), 0,
            {1'b0, 1'b1, 1'b0, 2'd0, 5'd19, 5'd18, 7'd43, 7'd42},   14'b100010_1000_0010);

    rst = 1'b1;
    bus.T1 = 1'b0; bus.RC = 1'b0; bus.CM = 1'b0; bus.WORD_NUM = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Unsynced idle cycles with RC high: nothing may be sampled or flagged.
    bus.RC = 1'b1; bus.CM = 1'b1;
    repeat (5) begin @(posedge clk); @(negedge clk); end
    chk("unsync_valid", 32'(bus.CMD_VALID), 32'd0);

    // Table: each word's result is checked during bit 2 of the following word.
    run_bits(vecs[0].cmd, vecs[0].drop, 7'd0, 1, 1);
    for (int i = 0; i < NV; i++) begin
      run_bits(vecs[i].cmd, vecs[i].drop, 7'd0, 2, 29);
      nxt      = (i + 1 < NV) ? vecs[i+1].cmd  : idle_w;
      nxt_drop = (i + 1 < NV) ? vecs[i+1].drop : 1;
      run_bits(nxt, nxt_drop, 7'd0, 1, 1);
      chk($sformatf("vec%0d_valid", i), 32'(bus.CMD_VALID), 32'd1);
      chk($sformatf("vec%0d_fld", i),   32'(act_fld()), 32'(vecs[i].e_fld));
      chk($sformatf("vec%0d_dec", i),   32'(act_dec()), 32'(vecs[i].e_dec));
    end
    chk("first_t1_no_syncerr", 32'(bus.SYNC_ERR), 32'd0);
    run_bits(idle_w, 1, 7'd0, 2, 29);

    // Held T_F=42, N_F=43: compare results valid from bit 2 through the whole word.
    wn_list[0] = 7'd41; wn_list[1] = 7'd42; wn_list[2] = 7'd43;
    for (int k = 0; k < 3; k++) begin
      run_bits(idle_w, 1, wn_list[k], 1, 1);
      chk($sformatf("tmatch_wn%0d_b2", wn_list[k]), 32'(bus.T_MATCH), 32'(wn_list[k] == 7'd42));
      chk($sformatf("nmatch_wn%0d_b2", wn_list[k]), 32'(bus.N_MATCH), 32'(wn_list[k] == 7'd43));
      run_bits(idle_w, 1, wn_list[k], 2, 29);
      chk($sformatf("tmatch_wn%0d_b29", wn_list[k]), 32'(bus.T_MATCH), 32'(wn_list[k] == 7'd42));
    end

    // Out-of-range word numbers never match even when the held fields equal them.
    run_bits(mk_cmd(1'b0, 5'd1, 5'd0, 2'd0, 7'd120, 1'b0, 7'd120, 1'b0), 0, 7'd0, 1, 29);
    run_bits(idle_w, 1, 7'd120, 1, 1);
    chk("range_dfield", 32'(bus.D_F), 32'd1);
    chk("range_tmatch", 32'(bus.T_MATCH), 32'd0);
    chk("range_nmatch", 32'(bus.N_MATCH), 32'd0);
    run_bits(idle_w, 1, 7'd120, 2, 29);

    // Stray T1 at bit 12 of a load: flag, resync to 1, discard the partial word.
    run_bits(mk_cmd(1'b0, 5'd31, 5'd21, 2'd0, 7'd0, 1'b0, 7'd0, 1'b0), 0, 7'd0, 1, 11);
    run_bits(idle_w, 0, 7'd0, 1, 1);
    chk("sync_err_set", 32'(bus.SYNC_ERR), 32'd1);
    run_bits(mk_cmd(1'b0, 5'd31, 5'd21, 2'd0, 7'd0, 1'b0, 7'd0, 1'b0), 0, 7'd0, 2, 29);
    run_bits(mk_cmd(1'b0, 5'd5, 5'd0, 2'd0, 7'd0, 1'b0, 7'd0, 1'b0), 0, 7'd0, 1, 1);
    chk("sync_abort_dfield", 32'(bus.D_F), 32'd1);
    run_bits(mk_cmd(1'b0, 5'd5, 5'd0, 2'd0, 7'd0, 1'b0, 7'd0, 1'b0), 0, 7'd0, 2, 29);
    run_bits(idle_w, 1, 7'd0, 1, 1);
    chk("resync_load_dfield", 32'(bus.D_F), 32'd5);
    chk("sync_err_sticky", 32'(bus.SYNC_ERR), 32'd1);
    run_bits(idle_w, 1, 7'd0, 2, 29);

    // Reset at bit 20 of a load, then a word's worth of cycles with no T1.
    run_bits(mk_cmd(1'b1, 5'd31, 5'd16, 2'd3, 7'd5, 1'b1, 7'd7, 1'b1), 0, 7'd0, 1, 19);
    rst = 1'b1; bus.T1 = 1'b0; bus.RC = 1'b1; bus.CM = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (29) begin @(posedge clk); @(negedge clk); end
    chk_all_zero("midload_rst");
    run_bits(mk_cmd(1'b0, 5'd9, 5'd0, 2'd0, 7'd0, 1'b0, 7'd0, 1'b0), 0, 7'd0, 1, 29);
    run_bits(idle_w, 1, 7'd0, 1, 1);
    chk("post_rst_valid",   32'(bus.CMD_VALID), 32'd1);
    chk("post_rst_dfield",  32'(bus.D_F), 32'd9);
    chk("post_rst_syncerr", 32'(bus.SYNC_ERR), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
